intr_ack_sequencer: RTL and testbench

CPU-side initiator of the 8259-style interrupt acknowledge protocol; it is the counterpart to the interrupt controller.
- Samples the controller's interrupt request at instruction boundaries.
- Generates the x86 two-pulse INTA cycle on interrupt_acknowledge_n.
- Captures the vector byte the controller drives, and hands it to the CPU core over a valid/ready handshake.
- Sits between the core's interrupt unit and the controller's interrupt_to_cpu, interrupt_acknowledge_n and data_bus_out/data_bus_io pins.

---
 rtl/intr_ack_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_intr_ack_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/intr_ack_sequencer.sv
// CPU-side 8259 interrupt-acknowledge initiator: two-pulse INTA cycle, vector capture, valid/ready hand-off.
// Optional automatic non-specific EOI write is enabled by defining INTR_ACK_AUTO_EOI_EN.
module intr_ack_sequencer #(
  parameter int INTA_LOW_CYCLES = 3,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intr,
  input  logic        if_flag,
  input  logic        inst_boundary,
  output logic        inta_n,
  input  logic [15:0] pic_data_in,
  input  logic        pic_data_drive,
  output logic [7:0]  vector,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic        busy,
  output logic        spurious,
  input  logic        eoi_req,
  output logic        eoi_done,
  output logic        pic_cs,
  output logic        pic_we,
  output logic        pic_addr,
  output logic [15:0] pic_wdata,
  input  logic        pic_ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INTA1   = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_INTA2   = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_PRESENT = 3'd5;
  localparam logic [2:0] S_EOI_WR  = 3'd6;

  localparam int CNT_MAX = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LOW_LD = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(INTA_GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          loaded;
  logic          intr_meta, intr_s;
  logic          eoi_start;
  logic          unused_hi;

  assign unused_hi = &{1'b0, pic_data_in[15:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intr_meta <= 1'b0;
      intr_s    <= 1'b0;
    end else begin
      intr_meta <= intr;
      intr_s    <= intr_meta;
    end
  end

  // cnt counts down from (length-1); a phase ends on the edge where it reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      loaded       <= 1'b0;
      inta_n       <= 1'b1;
      vector       <= '0;
      vector_valid <= 1'b0;
      spurious     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      spurious <= 1'b0;
      case (state)
        S_IDLE: begin
          if (eoi_start) begin
            state <= S_EOI_WR;
            busy  <= 1'b1;
          end else if (intr_s && if_flag && inst_boundary) begin
            state  <= S_INTA1;
            busy   <= 1'b1;
            inta_n <= 1'b0;
            cnt    <= LOW_LD;
            loaded <= 1'b0;
          end
        end
        S_INTA1: begin
          if (cnt == '0) begin
            state  <= S_GAP;
            inta_n <= 1'b1;
            cnt    <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state  <= S_INTA2;
            inta_n <= 1'b0;
            cnt    <= LOW_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_INTA2: begin
          if (pic_data_drive) begin
            vector <= pic_data_in[7:0];
            loaded <= 1'b1;
          end
          if (cnt == '0) begin
            state  <= S_CHK;
            inta_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // INTA released for one cycle before the vector is offered or declared spurious
        S_CHK: begin
          if (loaded) begin
            state        <= S_PRESENT;
            vector_valid <= 1'b1;
          end else begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            spurious <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (vector_ready) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            vector_valid <= 1'b0;
          end
        end
        S_EOI_WR: begin
          if (pic_ack) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          inta_n       <= 1'b1;
          vector_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTR_ACK_AUTO_EOI_EN
  logic eoi_pending;
  logic eoi_wr;

  assign eoi_start = (state == S_IDLE) && eoi_pending;

  // requests arriving while the write is in flight fold into that write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eoi_pending <= 1'b0;
      eoi_wr      <= 1'b0;
      eoi_done    <= 1'b0;
    end else begin
      eoi_done <= 1'b0;
      if (state == S_EOI_WR && pic_ack) begin
        eoi_pending <= 1'b0;
        eoi_wr      <= 1'b0;
        eoi_done    <= 1'b1;
      end else begin
        if (eoi_req && state != S_EOI_WR) eoi_pending <= 1'b1;
        if (eoi_start) eoi_wr <= 1'b1;
      end
    end
  end

  assign pic_cs    = eoi_wr;
  assign pic_we    = eoi_wr;
  assign pic_addr  = 1'b0;
  assign pic_wdata = eoi_wr ? 16'h0020 : 16'h0000;
`else
  logic unused_eoi;

  assign unused_eoi = &{1'b0, eoi_req};
  assign eoi_start  = 1'b0;
  assign eoi_done   = 1'b0;
  assign pic_cs     = 1'b0;
  assign pic_we     = 1'b0;
  assign pic_addr   = 1'b0;
  assign pic_wdata  = 16'h0000;
`endif

endmodule

// File: tb/tb_intr_ack_sequencer.sv
// Scoreboard bench for intr_ack_sequencer: expected vectors/spurious markers queued at drive time.
module tb_intr_ack_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        intr = 1'b0, if_flag = 1'b0, inst_boundary = 1'b0;
  logic        inta_n;
  logic [15:0] pic_data_in = 16'h0;
  logic        pic_data_drive = 1'b0;
  logic [7:0]  vector;
  logic        vector_valid, vector_ready = 1'b0;
  logic        busy, spurious;
  logic        eoi_req = 1'b0, eoi_done;
  logic        pic_cs, pic_we, pic_addr;
  logic [15:0] pic_wdata;
  logic        pic_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  last_vec = 8'h00;
  localparam logic [31:0] SPUR = 32'hFFFF_FFFF;

  intr_ack_sequencer #(.INTA_LOW_CYCLES(3), .INTA_GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .intr(intr), .if_flag(if_flag), .inst_boundary(inst_boundary),
    .inta_n(inta_n), .pic_data_in(pic_data_in), .pic_data_drive(pic_data_drive),
    .vector(vector), .vector_valid(vector_valid), .vector_ready(vector_ready),
    .busy(busy), .spurious(spurious), .eoi_req(eoi_req), .eoi_done(eoi_done),
    .pic_cs(pic_cs), .pic_we(pic_we), .pic_addr(pic_addr), .pic_wdata(pic_wdata),
    .pic_ack(pic_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic sb_pop(output logic [31:0] e);
    chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0BAD_0BAD;
  endtask

  // Called at a negedge; the boundary pulse occupies cycle N.
  task automatic run_seq(input bit drv, input logic [7:0] v, input int rdy_dly,
                         input bit drop, input bit eoi);
    logic [31:0] e;
    inst_boundary = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      inst_boundary = (k == 5);
      vector_ready  = (k == 3);
      eoi_req       = eoi && (k == 2);
      if (k <= 9) chk($sformatf("inta_n_c%0d", k), inta_n, (k <= 3 || (k >= 6 && k <= 8)) ? 0 : 1);
      if (k == 1) chk("busy_start", busy, 1);
      if (drop && k == 4) intr = 1'b0;
      if (k == 6) begin
        if (drv) begin
          pic_data_drive = 1'b1;
          pic_data_in    = {8'h5A, ~v};
        end else begin
          exp_q.push_back(SPUR);
        end
      end
      if (k == 7 && drv) begin
        pic_data_in = {8'hC3, v};
        exp_q.push_back({24'h0, v});
      end
      if (k == 8) pic_data_drive = 1'b0;
      if (k == 9) begin
        chk("valid_early", vector_valid, 0);
        chk("spur_early", spurious, 0);
      end
      if (k <= 9) chk("cs_during_inta", pic_cs, 0);
    end
    if (drv) begin
      chk("valid_n10", vector_valid, 1);
      chk("spur_n10", spurious, 0);
      sb_pop(e);
      chk("vector", {24'h0, vector}, e);
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk);
        chk("valid_hold", vector_valid, 1);
        chk("vector_hold", {24'h0, vector}, e);
      end
      vector_ready = 1'b1;
      @(negedge clk);
      vector_ready = 1'b0;
      chk("valid_clr", vector_valid, 0);
      chk("busy_clr", busy, 0);
      last_vec = v;
    end else begin
      chk("spur_pulse", spurious, 1);
      chk("valid_spur", vector_valid, 0);
      sb_pop(e);
      chk("sb_spur", spurious ? SPUR : {24'h0, vector}, e);
      chk("vector_kept", vector, last_vec);
      @(negedge clk);
      chk("spur_once", spurious, 0);
      chk("busy_spur", busy, 0);
    end
  endtask

  task automatic eoi_check;
`ifdef INTR_ACK_AUTO_EOI_EN
    chk("eoi_wait_idle", pic_cs, 0);
    @(negedge clk);
    chk("eoi_cs", pic_cs, 1);
    chk("eoi_we", pic_we, 1);
    chk("eoi_addr", pic_addr, 0);
    chk("eoi_wdata", pic_wdata, 16'h0020);
    eoi_req = 1'b1;
    @(negedge clk);
    eoi_req = 1'b0;
    chk("eoi_cs_hold1", pic_cs, 1);
    @(negedge clk);
    chk("eoi_cs_hold2", pic_cs, 1);
    pic_ack = 1'b1;
    @(negedge clk);
    pic_ack = 1'b0;
    chk("eoi_cs_off", pic_cs, 0);
    chk("eoi_we_off", pic_we, 0);
    chk("eoi_done", eoi_done, 1);
    @(negedge clk);
    chk("eoi_done_once", eoi_done, 0);
    chk("eoi_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("eoi_merged", pic_cs, 0);
    end
`else
    for (int i = 0; i < 4; i++) begin
      eoi_req = (i == 0);
      @(negedge clk);
      chk("eoi_off_cs", pic_cs, 0);
      chk("eoi_off_done", eoi_done, 0);
      chk("eoi_off_wdata", pic_wdata, 16'h0);
      chk("eoi_off_busy", busy, 0);
    end
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_inta_n", inta_n, 1);
    chk("rst_valid", vector_valid, 0);
    chk("rst_vector", vector, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spur", spurious, 0);
    chk("rst_cs", pic_cs, 0);
    chk("rst_done", eoi_done, 0);
    reset = 1'b0;
    intr = 1'b1;
    repeat (3) @(negedge clk);

    // interrupts masked: boundaries must not start an INTA cycle
    for (int i = 0; i < 12; i++) begin
      inst_boundary = (i % 3 == 0);
      @(negedge clk);
      chk("masked_inta_n", inta_n, 1);
    end
    inst_boundary = 1'b0;
    if_flag = 1'b1;

    run_seq(1'b1, 8'h0B, 0, 1'b0, 1'b0);
    run_seq(1'b1, 8'h0B, 5, 1'b0, 1'b0);
    run_seq(1'b0, 8'h00, 0, 1'b0, 1'b0);
    run_seq(1'b1, 8'h77, 1, 1'b1, 1'b0);
    intr = 1'b1;
    repeat (3) @(negedge clk);
    run_seq(1'b1, 8'hE4, 2, 1'b0, 1'b1);
    eoi_check();

    // reset during INTA1 releases inta_n without a clock edge
    inst_boundary = 1'b1;
    @(negedge clk);
    inst_boundary = 1'b0;
    @(negedge clk);
    chk("pre_rst_inta_n", inta_n, 0);
    reset = 1'b1;
    #1;
    chk("async_rst_inta_n", inta_n, 1);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
